// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
//   state_t  : controller states (IDLE, RUN, DONE), 2-bit encoding
//   SLICE_W  : width of the reused CLA slice (one digit)
//   idx_w()  : width of the digit index for a given digit count
package cla_seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  // A one-digit index would be zero-width; WIDTH >= 8 keeps nslice >= 2.
  function automatic int idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
//   in_*   : operand request (valid/ready) from the producer
//   out_*  : result (valid/ready) to the consumer
//   busy   : controller is in RUN or DONE
// modport slave  : the adder side
// modport master : the producer/consumer side
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_carry, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_carry, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow, busy
  );
endinterface

// File: rtl/cla_seq_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder digit.
//   i_a, i_b : digit operands
//   i_cin    : carry in
//   o_sum    : digit sum
//   o_cout   : carry out
module cla4_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every carry is expanded directly from g/p and cin (no ripple).
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract that reuses one 4-bit CLA slice over a
// WIDTH-bit operand pair, one digit per clock, LSB digit first.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : operand/result handshake (cla_seq_adder_if.slave)
// Result is presented NSLICE edges after the accept edge and held until
// the consumer takes it; one IDLE cycle always follows a result.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  cla_seq_adder_if.slave      bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = idx_w(NSLICE);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_cy;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;     // B_eff: already inverted for subtract
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [SLICE_W-1:0] w_a_dig;
  logic [SLICE_W-1:0] w_b_dig;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_last;

  assign w_a_dig = r_a[{r_idx, 2'b00} +: SLICE_W];
  assign w_b_dig = r_b[{r_idx, 2'b00} +: SLICE_W];
  assign w_last  = (r_idx == IW'(NSLICE - 1));

  cla4_slice u_slice (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_cin  (r_cy),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Subtract is A + ~B + ~bin, so the operation kind is fully encoded in
  // B_eff and the initial carry; nothing downstream needs a separate flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cy    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            r_cy    <= bus.in_sub ? ~bus.in_carry : bus.in_carry;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: SLICE_W] <= w_sum;
          r_cy  <= w_cout;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            // Flags latched from the final digit as the result is presented.
            r_cout  <= w_cout;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_sum[SLICE_W-1] != r_a[WIDTH-1]);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.out_valid    = (r_state == S_DONE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.out_sum      = r_sum;
  assign bus.out_carry    = r_cout;
  assign bus.out_overflow = r_ovf;
endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;
  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cla_seq_adder_if #(.WIDTH(W)) bus ();

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  // Returns {overflow, carry, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
    int unsigned ua, ub, uc, full;
    logic [W-1:0] sum;
    logic cy, ovf;
    ua = a; ub = b; uc = c;
    if (!s) begin
      full = ua + ub + uc;
      sum  = full[W-1:0];
      cy   = full[W];
      ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    end else begin
      full = ua - ub - uc;
      sum  = full[W-1:0];
      cy   = (ua >= ub + uc);
      ovf  = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
    end
    return {ovf, cy, sum};
  endfunction

  // One full transaction: accept, latency check, result check, optional
  // backpressure of `hold` cycles with input noise, then the handshake.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input int hold, input string tag);
    logic [W+1:0] e;
    int n;
    e = ref_op(a, b, c, s);
    n = 0;
    while (!bus.in_ready && n < 20) begin step(); n++; end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a = a; bus.in_b = b; bus.in_carry = c; bus.in_sub = s;
    bus.in_valid = 1'b1;
    step();                                  // accept edge
    bus.in_valid = 1'b0;
    bus.in_a = W'($urandom); bus.in_b = W'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin step(); n++; end
    chk({tag, "_latency"}, 32'(n), 32'(NSLICE));
    chk({tag, "_sum"},   32'(bus.out_sum),      32'(e[W-1:0]));
    chk({tag, "_carry"}, 32'(bus.out_carry),    32'(e[W]));
    chk({tag, "_ovf"},   32'(bus.out_overflow), 32'(e[W+1]));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_a = W'($urandom);
      step();
      chk({tag, "_hold_sum"},   32'(bus.out_sum),   32'(e[W-1:0]));
      chk({tag, "_hold_carry"}, 32'(bus.out_carry), 32'(e[W]));
      chk({tag, "_hold_ovf"},   32'(bus.out_overflow), 32'(e[W+1]));
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
      chk({tag, "_hold_busy"},  32'(bus.busy),      32'd1);
    end
    bus.out_ready = 1'b1;
    step();                                  // result handshake edge
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
    chk({tag, "_idle_busy"},  32'(bus.busy),      32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_carry = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid),    32'd0);
    chk("rst_busy",  32'(bus.busy),         32'd0);
    chk("rst_sum",   32'(bus.out_sum),      32'd0);
    chk("rst_carry", 32'(bus.out_carry),    32'd0);
    chk("rst_ovf",   32'(bus.out_overflow), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(16'h00AF, 16'h00FF, 1'b1, 1'b0, 0, "add_af_ff");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_ripple");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_ovf_pos");
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, "add_ovf_neg");
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_borrow");
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
    do_op(16'h1357, 16'h2468, 1'b1, 1'b1, 5, "backpressure");
    // Next op must be accepted straight after the mandatory IDLE cycle.
    do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 0, "after_bp");

    // Abort two cycles into RUN: no partial result may surface.
    bus.in_a = 16'hFFFF; bus.in_b = 16'h0001; bus.in_carry = 1'b0; bus.in_sub = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus.out_valid),    32'd0);
    chk("abort_busy",  32'(bus.busy),         32'd0);
    chk("abort_sum",   32'(bus.out_sum),      32'd0);
    chk("abort_carry", 32'(bus.out_carry),    32'd0);
    chk("abort_ovf",   32'(bus.out_overflow), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    n = 0;
    for (int k = 0; k < NSLICE + 2; k++) begin
      step();
      if (bus.out_valid) n++;
    end
    chk("abort_no_result", 32'(n), 32'd0);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "post_abort");

    for (int i = 0; i < 24; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-precision add/subtract controller that sequences a single 4-bit carry-lookahead slice over a WIDTH-bit operand pair, one 4-bit digit per clock, LSB digit first.
- Trades latency for area: one CLA slice is reused instead of instantiating WIDTH/4 slices.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready) in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, derived digit count; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept an operand request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_carry  input  1  carry-in for add; borrow-in for subtract.
- in_sub  input  1  0 = A+B+cin; 1 = A-B-bin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_carry  output  1  final carry-out. For subtract, 1 = no borrow.
- out_overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state): state = IDLE; digit index = 0; carry reg = 0; operand regs = 0; out_sum = 0; out_carry = 0; out_overflow = 0; out_valid = 0; busy = 0; in_ready = 1 after deassertion.
- A reset mid-RUN or mid-DONE aborts the operation. No partial result is ever presented.
- States:
  - IDLE: in_ready = 1.
    - On in_valid & in_ready: capture in_a into A_reg.
    - Capture B_eff = in_sub ? ~in_b : in_b.
    - Carry reg = in_sub ? ~in_carry : in_carry.
    - Latch in_sub; index = 0; go to RUN.
  - RUN: in_ready = 0.
    - Each cycle, the slice adds A_reg[4i+3:4i] + B_eff[4i+3:4i] + carry reg.
    - The slice sum is written into out_sum[4i+3:4i]; carry reg takes the slice carry-out; index increments.
    - When index == NSLICE-1, transition to DONE at that edge.
  - DONE: out_valid = 1.
    - out_carry = carry reg.
    - out_overflow = (A_reg[MSB] == B_eff[MSB]) & (out_sum[MSB] != A_reg[MSB]).
    - Hold all outputs stable until out_valid & out_ready; then go to IDLE.
- Latency: acceptance edge at k gives out_valid high after edge k+NSLICE (4 cycles for WIDTH=16).
- Throughput: one op per NSLICE+2 cycles minimum. in_ready stays 0 in DONE even if out_ready is high; a mandatory IDLE cycle follows each result.
- in_valid and input changes outside IDLE are ignored; operands are fully registered at acceptance.
- out_sum is only meaningful while out_valid = 1. Between results it holds partial/previous data. out_carry and out_overflow are updated only on entry to DONE.
- All arithmetic wraps mod 2^WIDTH. No saturation.
- Carry-chain boundary: a carry generated in digit 0 must propagate through every digit to out_carry (full-ripple case).

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, DONE), 2-bit encoding;
  - SLICE_W = 4 constant;
  - index width function clog2(NSLICE).
- One sub-module: cla4_slice, a combinational 4-bit carry-lookahead adder.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], cout.
  - Built from generate/propagate terms; instantiated exactly once.

Test Plan (WIDTH=16):
- Add 0x00AF + 0x00FF, cin=1 -> out_sum=0x01AF, out_carry=0, out_overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- Add 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, out_carry=1, out_overflow=0 (carry ripples through all 4 digits).
- Add 0x7FFF + 0x0001, cin=0 -> out_sum=0x8000, out_carry=0, out_overflow=1. Also 0x8000 + 0x8000 -> 0x0000, carry=1, ovf=1.
- Sub 0x0005 - 0x0007, bin=0 -> out_sum=0xFFFE, out_carry=0 (borrow), ovf=0. Sub 0x8000 - 0x0001 -> 0x7FFF, carry=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles while toggling in_valid and in_a.
  - Expect outputs stable, in_ready=0, busy=1.
  - After the out_ready handshake: one IDLE cycle with in_ready=1, then the next op is accepted.
- Assert rst for 1 cycle after 2 RUN cycles.
  - Expect all outputs 0 immediately (async) and in_ready=1 after release.
  - The following 0x1234 + 0x4321, cin=0 -> 0x5555, carry=0.
